// File: rtl/branch_resolver_if.sv
// Signal bundle between the IF/ID pipeline stages and the branch resolver.
// The slave modport is the resolver side and the master modport is the pipeline/driver side.
interface branch_resolver_if;
  logic        stall;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pred_fallthru;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] lookup_pc;
  logic        bht_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  modport slave (
    input  stall, pred_valid, pred_pc, pred_taken, pred_target, pred_fallthru,
    input  resolve_valid, resolve_taken, lookup_pc,
    output bht_taken, flush, redirect_pc, branch_cnt, miss_cnt
  );

  modport master (
    output stall, pred_valid, pred_pc, pred_taken, pred_target, pred_fallthru,
    output resolve_valid, resolve_taken, lookup_pc,
    input  bht_taken, flush, redirect_pc, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// 8-entry 2-bit BHT with a one-deep pending branch. Prediction and flush are combinational and
// resolve in the same cycle; stall freezes all state and masks flush.
module branch_resolver (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave br
);
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthru;
  } pend_t;

  logic [7:0][1:0] bht;
  pend_t           pend_dat;
  logic            pend_vld;
  logic [15:0]     branch_cnt_q;
  logic [15:0]     miss_cnt_q;
  logic            accept;
  logic            mispredict;
  logic [2:0]      upd_idx;
  logic [1:0]      upd_cnt;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^{br.lookup_pc[31:5], br.lookup_pc[1:0],
                            pend_dat.pc[31:5], pend_dat.pc[1:0]};

  // Read port deliberately sees the pre-update table value.
  assign br.bht_taken  = bht[br.lookup_pc[4:2]][1];
  assign br.branch_cnt = branch_cnt_q;
  assign br.miss_cnt   = miss_cnt_q;

  always_comb begin
    accept         = br.resolve_valid && !br.stall && pend_vld && !rst;
    mispredict     = accept && (pend_dat.taken != br.resolve_taken);
    br.flush       = mispredict;
    br.redirect_pc = '0;
    if (mispredict) begin
      br.redirect_pc = pend_dat.taken ? pend_dat.fallthru : pend_dat.target;
    end
  end

  always_comb begin
    upd_idx = pend_dat.pc[4:2];
    upd_cnt = bht[upd_idx];
    if (br.resolve_taken && (upd_cnt != 2'b11)) begin
      upd_cnt = upd_cnt + 2'b01;
    end else if (!br.resolve_taken && (upd_cnt != 2'b00)) begin
      upd_cnt = upd_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bht          <= {8{2'b01}};
      pend_dat     <= '0;
      pend_vld     <= 1'b0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (!br.stall) begin
      if (accept) begin
        bht[upd_idx] <= upd_cnt;
        if (branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
        if (mispredict && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
      // A new IF branch is wrong-path and dropped when the older one mispredicts.
      if (br.pred_valid && !mispredict) begin
        pend_dat <= '{pc:       br.pred_pc,
                      taken:    br.pred_taken,
                      target:   br.pred_target,
                      fallthru: br.pred_fallthru};
        pend_vld <= 1'b1;
      end else if (accept) begin
        pend_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed expectations checked with immediate assertions.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  branch_resolver_if br ();

  branch_resolver dut (
    .clk (clk),
    .rst (rst),
    .br  (br)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] ft);
    br.pred_valid    = 1'b1;
    br.pred_pc       = pc;
    br.pred_taken    = tk;
    br.pred_target   = tgt;
    br.pred_fallthru = ft;
  endtask

  task automatic resolve(input logic tk);
    br.pred_valid    = 1'b0;
    br.resolve_valid = 1'b1;
    br.resolve_taken = tk;
  endtask

  task automatic idle();
    br.pred_valid    = 1'b0;
    br.resolve_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic exp, input string tag);
    br.lookup_pc = pc;
    #1;
    chk(tag, {31'd0, br.bht_taken}, {31'd0, exp});
  endtask

  initial begin
    br.stall = 1'b0;
    br.pred_valid = 1'b0; br.pred_pc = '0; br.pred_taken = 1'b0;
    br.pred_target = '0; br.pred_fallthru = '0;
    br.resolve_valid = 1'b0; br.resolve_taken = 1'b0; br.lookup_pc = '0;

    // Reset: outputs quiet while rst is high, then cleared state.
    tick();
    br.resolve_valid = 1'b1; br.resolve_taken = 1'b1;
    #1;
    chk("rst_flush", {31'd0, br.flush}, 32'd0);
    chk("rst_redirect", br.redirect_pc, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk("rst_branch_cnt", {16'd0, br.branch_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'd0, br.miss_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) look(32'(i * 4), 1'b0, "rst_bht");

    // Correct not-taken prediction on pc 0x10.
    pred(32'h10, 1'b0, 32'h40, 32'h14);
    tick();
    resolve(1'b0);
    #1;
    chk("ok_flush", {31'd0, br.flush}, 32'd0);
    chk("ok_redirect", br.redirect_pc, 32'd0);
    tick();
    idle();
    chk("ok_branch_cnt", {16'd0, br.branch_cnt}, 32'd1);
    chk("ok_miss_cnt", {16'd0, br.miss_cnt}, 32'd0);
    chk("ok_ctr4", {30'd0, dut.bht[4]}, 32'd0);

    // Taken mispredict on pc 0x20.
    pred(32'h20, 1'b0, 32'h80, 32'h24);
    tick();
    resolve(1'b1);
    #1;
    chk("mp_flush", {31'd0, br.flush}, 32'd1);
    chk("mp_redirect", br.redirect_pc, 32'h80);
    tick();
    idle();
    chk("mp_miss_cnt", {16'd0, br.miss_cnt}, 32'd1);
    chk("mp_branch_cnt", {16'd0, br.branch_cnt}, 32'd2);
    look(32'h20, 1'b1, "mp_bht");

    // Saturation on pc 0x1C: 01 -> 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 4; i++) begin
      pred(32'h1C, 1'b1, 32'h100, 32'h20);
      tick();
      resolve(1'b1);
      #1;
      chk("sat_flush", {31'd0, br.flush}, 32'd0);
      tick();
      idle();
      chk("sat_ctr7", {30'd0, dut.bht[7]}, (i == 0) ? 32'd2 : 32'd3);
    end
    pred(32'h1C, 1'b1, 32'h100, 32'h20);
    tick();
    resolve(1'b0);
    #1;
    chk("sat_nt_flush", {31'd0, br.flush}, 32'd1);
    chk("sat_nt_redirect", br.redirect_pc, 32'h20);
    tick();
    idle();
    chk("sat_nt_ctr7", {30'd0, dut.bht[7]}, 32'd2);
    look(32'h1C, 1'b1, "sat_nt_bht");
    chk("sat_branch_cnt", {16'd0, br.branch_cnt}, 32'd7);
    chk("sat_miss_cnt", {16'd0, br.miss_cnt}, 32'd2);

    // Back-to-back with mispredict: new branch at 0x24 is dropped.
    pred(32'h30, 1'b1, 32'h200, 32'h34);
    tick();
    br.resolve_valid = 1'b1; br.resolve_taken = 1'b0;
    pred(32'h24, 1'b0, 32'h300, 32'h28);
    #1;
    chk("b2b_flush", {31'd0, br.flush}, 32'd1);
    chk("b2b_redirect", br.redirect_pc, 32'h34);
    tick();
    chk("b2b_pend_vld", {31'd0, dut.pend_vld}, 32'd0);
    chk("b2b_branch_cnt", {16'd0, br.branch_cnt}, 32'd8);
    resolve(1'b1);
    #1;
    chk("b2b_ign_flush", {31'd0, br.flush}, 32'd0);
    tick();
    idle();
    chk("b2b_ign_branch_cnt", {16'd0, br.branch_cnt}, 32'd8);
    chk("b2b_ign_miss_cnt", {16'd0, br.miss_cnt}, 32'd3);

    // Back-to-back correct: old resolves, new at 0x0C loads and later mispredicts.
    pred(32'h08, 1'b0, 32'h400, 32'h0C);
    tick();
    br.resolve_valid = 1'b1; br.resolve_taken = 1'b0;
    pred(32'h0C, 1'b1, 32'h500, 32'h10);
    #1;
    chk("b2b_ok_flush", {31'd0, br.flush}, 32'd0);
    tick();
    chk("b2b_ok_pend_vld", {31'd0, dut.pend_vld}, 32'd1);
    resolve(1'b0);
    #1;
    chk("b2b_ok2_flush", {31'd0, br.flush}, 32'd1);
    chk("b2b_ok2_redirect", br.redirect_pc, 32'h10);
    tick();
    idle();
    chk("b2b_ok2_branch_cnt", {16'd0, br.branch_cnt}, 32'd10);
    chk("b2b_ok2_miss_cnt", {16'd0, br.miss_cnt}, 32'd4);
    chk("b2b_ok2_ctr3", {30'd0, dut.bht[3]}, 32'd0);

    // Stall masks a mispredicting resolution until it drops.
    pred(32'h14, 1'b0, 32'h600, 32'h18);
    tick();
    br.stall = 1'b1;
    resolve(1'b1);
    #1;
    chk("stall_flush", {31'd0, br.flush}, 32'd0);
    chk("stall_redirect", br.redirect_pc, 32'd0);
    tick();
    tick();
    chk("stall_branch_cnt", {16'd0, br.branch_cnt}, 32'd10);
    chk("stall_miss_cnt", {16'd0, br.miss_cnt}, 32'd4);
    chk("stall_ctr5", {30'd0, dut.bht[5]}, 32'd1);
    br.stall = 1'b0;
    #1;
    chk("unstall_flush", {31'd0, br.flush}, 32'd1);
    chk("unstall_redirect", br.redirect_pc, 32'h600);
    tick();
    idle();
    chk("unstall_miss_cnt", {16'd0, br.miss_cnt}, 32'd5);
    chk("unstall_ctr5", {30'd0, dut.bht[5]}, 32'd2);

    // Reset in the middle of a resolution.
    pred(32'h18, 1'b0, 32'h700, 32'h1C);
    tick();
    chk("mid_pend_vld", {31'd0, dut.pend_vld}, 32'd1);
    rst = 1'b1;
    resolve(1'b1);
    #1;
    chk("mid_rst_flush", {31'd0, br.flush}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("mid_rst_pend_vld", {31'd0, dut.pend_vld}, 32'd0);
    chk("mid_rst_miss_cnt", {16'd0, br.miss_cnt}, 32'd0);
    chk("mid_rst_branch_cnt", {16'd0, br.branch_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) look(32'(i * 4), 1'b0, "mid_rst_bht");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
